// File: rtl/flipper_unit.sv
// -----------------------------------------------------------------------------
// flipper_unit
//
// One pinball flipper: a frame-paced angle FSM plus a per-pixel bar renderer.
//
// The flipper is a bar pivoting at (PIVOT_X, PIVOT_Y). Its tip sits LENGTH
// pixels to the right of the pivot (MIRROR=0) or to the left (MIRROR=1),
// and DROP - angleStep*STEP_DY pixels below it. Pressing the button raises
// the bar one angle step every UP_FRAMES frames until it reaches the top
// position. Releasing it lowers the bar one step every DOWN_FRAMES frames
// until it is back at rest.
//
// Ports
//   clk             sole clock
//   reset           asynchronous, active-high
//   startOfFrame    one-cycle pulse per video frame; paces all motion
//   button          level, 1 = flipper commanded up
//   pixelX/pixelY   current VGA pixel (signed)
//   drawingRequest  pixel lies on the flipper bar (1-cycle latency)
//   RGBout          OBJECT_COLOR on the bar, 8'hFF (transparent) elsewhere
//   offsetX/Y       pixel offset from the pivot when on the bar, else 0
//   tipX/tipY       current tip position (signed)
//   angleStep       current angle index, 0 = rest
//   kick            1 while the flipper is rising
//   state           FSM state: REST=0, RISING=1, HOLD=2, FALLING=3
// -----------------------------------------------------------------------------
module flipper_unit #(
  parameter int          MIRROR       = 0,
  parameter int          PIVOT_X      = 185,
  parameter int          PIVOT_Y      = 400,
  parameter int          LENGTH       = 60,
  parameter int          THICKNESS    = 5,
  parameter int          N_STEPS      = 8,
  parameter int          DROP         = 30,
  parameter int          STEP_DY      = 10,
  parameter int          UP_FRAMES    = 1,
  parameter int          DOWN_FRAMES  = 2,
  parameter logic [7:0]  OBJECT_COLOR = 8'h5B
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               button,
  input  logic signed [10:0] pixelX,
  input  logic signed [10:0] pixelY,
  output logic               drawingRequest,
  output logic [7:0]         RGBout,
  output logic [10:0]        offsetX,
  output logic [10:0]        offsetY,
  output logic signed [10:0] tipX,
  output logic signed [10:0] tipY,
  output logic [3:0]         angleStep,
  output logic               kick,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    REST    = 2'd0,
    RISING  = 2'd1,
    HOLD    = 2'd2,
    FALLING = 2'd3
  } fsm_t;

  localparam logic [7:0] TRANSPARENT = 8'hFF;
  localparam logic [3:0] MAX_STEP    = 4'(N_STEPS - 1);
  localparam logic [3:0] UP_LAST     = 4'(UP_FRAMES - 1);
  localparam logic [3:0] DOWN_LAST   = 4'(DOWN_FRAMES - 1);

  // The tip X never moves; only its side of the pivot depends on MIRROR.
  localparam logic signed [10:0] TIP_X_C =
    11'((MIRROR != 0) ? (PIVOT_X - LENGTH) : (PIVOT_X + LENGTH));
  localparam logic signed [10:0] TIP_Y_REST = 11'(PIVOT_Y + DROP);

  fsm_t       state_q;
  logic [3:0] frame_cnt;

  // Clamp a candidate step to 0..N_STEPS-1 so the angle can never wrap.
  function automatic logic [3:0] sat_step(input int s);
    if (s < 0)
      return 4'd0;
    else if (s > N_STEPS - 1)
      return MAX_STEP;
    else
      return 4'(s);
  endfunction

  // Vertical pivot-to-tip offset for a given angle step (positive = below).
  function automatic logic signed [31:0] dy_of(input logic [3:0] s);
    return DROP - STEP_DY * int'(s);
  endfunction

  function automatic logic signed [10:0] tip_y_of(input logic [3:0] s);
    return 11'(PIVOT_Y + dy_of(s));
  endfunction

  assign state = state_q;

  // Angle FSM. Everything advances only on frame pulses; tipY and kick are
  // loaded together with the new step/state so they never lag by a cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= REST;
      angleStep <= 4'd0;
      frame_cnt <= 4'd0;
      kick      <= 1'b0;
      tipX      <= TIP_X_C;
      tipY      <= TIP_Y_REST;
    end else begin
      tipX <= TIP_X_C;
      if (startOfFrame) begin
        case (state_q)
          REST: begin
            angleStep <= 4'd0;
            tipY      <= TIP_Y_REST;
            frame_cnt <= 4'd0;
            if (button) begin
              state_q <= RISING;
              kick    <= 1'b1;
            end
          end

          RISING: begin
            if (!button) begin
              // Early release: drop from wherever we are, no step change.
              state_q   <= FALLING;
              frame_cnt <= 4'd0;
              kick      <= 1'b0;
            end else if (frame_cnt >= UP_LAST) begin
              frame_cnt <= 4'd0;
              angleStep <= sat_step(int'(angleStep) + 1);
              tipY      <= tip_y_of(sat_step(int'(angleStep) + 1));
              if (int'(angleStep) + 1 >= N_STEPS - 1) begin
                state_q <= HOLD;
                kick    <= 1'b0;
              end
            end else begin
              frame_cnt <= frame_cnt + 4'd1;
            end
          end

          HOLD: begin
            angleStep <= MAX_STEP;
            tipY      <= tip_y_of(MAX_STEP);
            frame_cnt <= 4'd0;
            if (!button)
              state_q <= FALLING;
          end

          FALLING: begin
            if (button) begin
              // Re-trigger mid-fall: climb again from the current step.
              state_q   <= RISING;
              frame_cnt <= 4'd0;
              kick      <= 1'b1;
            end else if (frame_cnt >= DOWN_LAST) begin
              frame_cnt <= 4'd0;
              angleStep <= sat_step(int'(angleStep) - 1);
              tipY      <= tip_y_of(sat_step(int'(angleStep) - 1));
              if (int'(angleStep) <= 1)
                state_q <= REST;
            end else begin
              frame_cnt <= frame_cnt + 4'd1;
            end
          end

          default: begin
            state_q <= REST;
          end
        endcase
      end
    end
  end

  // Stage p0: pixel geometry relative to the pivot, evaluated against the
  // current angle. The bar is the band around the pivot-tip segment:
  // |v*LENGTH - dy*u| <= LENGTH*THICKNESS is the perpendicular-distance test
  // scaled by LENGTH so no division is needed; the box limits cap the ends.
  logic signed [31:0] px_p0;
  logic signed [31:0] py_p0;
  logic signed [31:0] u_p0;
  logic signed [31:0] v_p0;
  logic signed [31:0] dy_p0;
  logic signed [31:0] cross_p0;
  logic signed [31:0] abs_cross_p0;
  logic signed [31:0] dy_lo_p0;
  logic signed [31:0] dy_hi_p0;
  logic               inside_p0;

  always_comb begin
    px_p0        = {{21{pixelX[10]}}, pixelX};
    py_p0        = {{21{pixelY[10]}}, pixelY};
    u_p0         = (MIRROR != 0) ? (PIVOT_X - px_p0) : (px_p0 - PIVOT_X);
    v_p0         = py_p0 - PIVOT_Y;
    dy_p0        = dy_of(angleStep);
    cross_p0     = v_p0 * LENGTH - dy_p0 * u_p0;
    abs_cross_p0 = (cross_p0 < 0) ? -cross_p0 : cross_p0;
    dy_lo_p0     = (dy_p0 < 0) ? dy_p0 : 32'sd0;
    dy_hi_p0     = (dy_p0 > 0) ? dy_p0 : 32'sd0;
    inside_p0    = (abs_cross_p0 <= LENGTH * THICKNESS) &&
                   (u_p0 >= -THICKNESS) &&
                   (u_p0 <= LENGTH + THICKNESS) &&
                   (v_p0 >= dy_lo_p0 - THICKNESS) &&
                   (v_p0 <= dy_hi_p0 + THICKNESS);
  end

  // Stage p1: registered drawing outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drawingRequest <= 1'b0;
      RGBout         <= TRANSPARENT;
      offsetX        <= 11'd0;
      offsetY        <= 11'd0;
    end else if (inside_p0) begin
      drawingRequest <= 1'b1;
      RGBout         <= OBJECT_COLOR;
      offsetX        <= u_p0[10:0];
      offsetY        <= v_p0[10:0];
    end else begin
      drawingRequest <= 1'b0;
      RGBout         <= TRANSPARENT;
      offsetX        <= 11'd0;
      offsetY        <= 11'd0;
    end
  end

endmodule

// File: tb/tb_flipper_unit.sv
// -----------------------------------------------------------------------------
// tb_flipper_unit
//
// Bench for flipper_unit: a left flipper (MIRROR=0) and a right flipper
// (MIRROR=1) with default geometry share all inputs. Motion is compared
// against a frame-level model of the flipper's behaviour; drawing against a
// direct evaluation of the bar geometry.
// -----------------------------------------------------------------------------
module tb_flipper_unit;

  localparam int UP   = 1;
  localparam int DOWN = 2;
  localparam int NST  = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic               sof;
  logic               button;
  logic signed [10:0] pixelX;
  logic signed [10:0] pixelY;

  logic               dr0, kick0, dr1, kick1;
  logic [7:0]         rgb0, rgb1;
  logic [10:0]        offX0, offY0, offX1, offY1;
  logic signed [10:0] tipX0, tipY0, tipX1, tipY1;
  logic [3:0]         ang0, ang1;
  logic [1:0]         st0, st1;

  flipper_unit #(.MIRROR(0)) dut0 (
    .clk(clk), .reset(reset), .startOfFrame(sof), .button(button),
    .pixelX(pixelX), .pixelY(pixelY),
    .drawingRequest(dr0), .RGBout(rgb0), .offsetX(offX0), .offsetY(offY0),
    .tipX(tipX0), .tipY(tipY0), .angleStep(ang0), .kick(kick0), .state(st0)
  );

  flipper_unit #(.MIRROR(1)) dut1 (
    .clk(clk), .reset(reset), .startOfFrame(sof), .button(button),
    .pixelX(pixelX), .pixelY(pixelY),
    .drawingRequest(dr1), .RGBout(rgb1), .offsetX(offX1), .offsetY(offY1),
    .tipX(tipX1), .tipY(tipY1), .angleStep(ang1), .kick(kick1), .state(st1)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state: mode 0 rest, 1 rising, 2 hold, 3 falling.
  int m_state;
  int m_step;
  int m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_step  = 0;
    m_cnt   = 0;
  endtask

  // One frame of flipper behaviour: count frames spent in a moving phase
  // and take a step once the per-step frame budget has elapsed.
  task automatic model_frame(input bit b);
    case (m_state)
      0: begin
        m_step = 0;
        if (b) begin m_state = 1; m_cnt = 0; end
      end
      1: begin
        if (!b) begin
          m_state = 3; m_cnt = 0;
        end else begin
          m_cnt++;
          if (m_cnt >= UP) begin
            m_cnt = 0;
            m_step++;
            if (m_step >= NST - 1) begin m_step = NST - 1; m_state = 2; end
          end
        end
      end
      2: begin
        if (!b) begin m_state = 3; m_cnt = 0; end
      end
      default: begin
        if (b) begin
          m_state = 1; m_cnt = 0;
        end else begin
          m_cnt++;
          if (m_cnt >= DOWN) begin
            m_cnt = 0;
            m_step--;
            if (m_step <= 0) begin m_step = 0; m_state = 0; end
          end
        end
      end
    endcase
  endtask

  function automatic bit ref_inside(input int px, input int py, input int step,
                                    input int mirror, output int u, output int v);
    longint dy;
    longint cr;
    dy = 30 - step * 10;
    u  = (mirror != 0) ? (185 - px) : (px - 185);
    v  = py - 400;
    cr = longint'(v) * 60 - dy * u;
    if (cr < 0) cr = -cr;
    return (cr <= 300) && (u >= -5) && (u <= 65) &&
           (v >= ((dy < 0) ? dy : 0) - 5) && (v <= ((dy > 0) ? dy : 0) + 5);
  endfunction

  // Frame pulse; the button is toggled in the following idle cycle, which
  // must have no effect because nothing moves without a frame pulse.
  task automatic do_frame(input bit b);
    @(negedge clk); button = b; sof = 1'b1;
    @(negedge clk); sof = 1'b0; button = ~b;
    @(negedge clk); button = b;
    model_frame(b);
  endtask

  task automatic check_fsm(input string tag);
    chk($sformatf("%s state0", tag), 32'(st0), 32'(m_state));
    chk($sformatf("%s step0", tag), 32'(ang0), 32'(m_step));
    chk($sformatf("%s tipY0", tag), 32'(tipY0), 32'(430 - 10 * m_step));
    chk($sformatf("%s kick0", tag), 32'(kick0), 32'(m_state == 1));
    chk($sformatf("%s state1", tag), 32'(st1), 32'(m_state));
    chk($sformatf("%s step1", tag), 32'(ang1), 32'(m_step));
  endtask

  task automatic check_pixel(input int px, input int py, input string tag);
    int u0, v0, u1, v1;
    bit in0, in1;
    @(negedge clk); pixelX = 11'(px); pixelY = 11'(py);
    @(negedge clk);
    in0 = ref_inside(px, py, m_step, 0, u0, v0);
    in1 = ref_inside(px, py, m_step, 1, u1, v1);
    chk($sformatf("%s dr0 (%0d,%0d)", tag, px, py), 32'(dr0), 32'(in0));
    chk($sformatf("%s rgb0", tag), 32'(rgb0), in0 ? 32'h5B : 32'hFF);
    chk($sformatf("%s offX0", tag), 32'(offX0), in0 ? 32'(u0 & 2047) : 32'd0);
    chk($sformatf("%s offY0", tag), 32'(offY0), in0 ? 32'(v0 & 2047) : 32'd0);
    chk($sformatf("%s dr1 (%0d,%0d)", tag, px, py), 32'(dr1), 32'(in1));
    chk($sformatf("%s rgb1", tag), 32'(rgb1), in1 ? 32'h5B : 32'hFF);
    chk($sformatf("%s offX1", tag), 32'(offX1), in1 ? 32'(u1 & 2047) : 32'd0);
    chk($sformatf("%s offY1", tag), 32'(offY1), in1 ? 32'(v1 & 2047) : 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk($sformatf("%s state0", tag), 32'(st0), 32'd0);
    chk($sformatf("%s step0", tag), 32'(ang0), 32'd0);
    chk($sformatf("%s kick0", tag), 32'(kick0), 32'd0);
    chk($sformatf("%s tipX0", tag), 32'(tipX0), 32'd245);
    chk($sformatf("%s tipY0", tag), 32'(tipY0), 32'd430);
    chk($sformatf("%s dr0", tag), 32'(dr0), 32'd0);
    chk($sformatf("%s rgb0", tag), 32'(rgb0), 32'hFF);
    chk($sformatf("%s offX0", tag), 32'(offX0), 32'd0);
    chk($sformatf("%s offY0", tag), 32'(offY0), 32'd0);
    chk($sformatf("%s state1", tag), 32'(st1), 32'd0);
    chk($sformatf("%s kick1", tag), 32'(kick1), 32'd0);
    chk($sformatf("%s tipX1", tag), 32'(tipX1), 32'd125);
    chk($sformatf("%s tipY1", tag), 32'(tipY1), 32'd430);
    chk($sformatf("%s dr1", tag), 32'(dr1), 32'd0);
    chk($sformatf("%s rgb1", tag), 32'(rgb1), 32'hFF);
  endtask

  typedef struct {
    int         px;
    int         py;
    bit         dr;
    logic [7:0] rgb;
    int         ox;
    int         oy;
  } vec_t;

  initial begin
    vec_t tbl[12];
    bit   btn;
    int   ul, vl, px, py;

    // Left flipper at rest (dy=30): line v = u/2, band |v*60-30u| <= 300.
    tbl[0]  = '{215, 415, 1'b1, 8'h5B, 30, 15};
    tbl[1]  = '{215, 440, 1'b0, 8'hFF, 0, 0};
    tbl[2]  = '{185, 400, 1'b1, 8'h5B, 0, 0};
    tbl[3]  = '{245, 430, 1'b1, 8'h5B, 60, 30};
    tbl[4]  = '{250, 430, 1'b1, 8'h5B, 65, 30};
    tbl[5]  = '{251, 430, 1'b0, 8'hFF, 0, 0};
    tbl[6]  = '{180, 400, 1'b1, 8'h5B, 2043, 0};
    tbl[7]  = '{179, 400, 1'b0, 8'hFF, 0, 0};
    tbl[8]  = '{215, 410, 1'b1, 8'h5B, 30, 10};
    tbl[9]  = '{215, 409, 1'b0, 8'hFF, 0, 0};
    tbl[10] = '{215, 420, 1'b1, 8'h5B, 30, 20};
    tbl[11] = '{215, 421, 1'b0, 8'hFF, 0, 0};

    reset = 1'b1; sof = 1'b0; button = 1'b0; pixelX = 11'sd215; pixelY = 11'sd415;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;

    // Idle at rest.
    for (int k = 1; k <= 10; k++) begin
      do_frame(1'b0);
      check_fsm($sformatf("idle f%0d", k));
    end

    // Drawing at rest, left flipper.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); pixelX = 11'(tbl[i].px); pixelY = 11'(tbl[i].py);
      @(negedge clk);
      chk($sformatf("tbl%0d dr", i), 32'(dr0), 32'(tbl[i].dr));
      chk($sformatf("tbl%0d rgb", i), 32'(rgb0), 32'(tbl[i].rgb));
      chk($sformatf("tbl%0d offX", i), 32'(offX0), 32'(tbl[i].ox));
      chk($sformatf("tbl%0d offY", i), 32'(offY0), 32'(tbl[i].oy));
    end

    // Right flipper at rest.
    @(negedge clk); pixelX = 11'sd155; pixelY = 11'sd415;
    @(negedge clk);
    chk("mirror tipX", 32'(tipX1), 32'd125);
    chk("mirror dr", 32'(dr1), 32'd1);
    chk("mirror offX", 32'(offX1), 32'd30);
    chk("mirror offY", 32'(offY1), 32'd15);

    // Hold the button: RISING at frame 1, steps 1..7 on frames 2..8.
    for (int k = 1; k <= 9; k++) begin
      do_frame(1'b1);
      chk($sformatf("rise f%0d state", k), 32'(st0), (k < 8) ? 32'd1 : 32'd2);
      chk($sformatf("rise f%0d step", k), 32'(ang0), 32'((k < 8) ? k - 1 : 7));
      chk($sformatf("rise f%0d kick", k), 32'(kick0), 32'(k < 8));
      check_fsm($sformatf("rise f%0d", k));
    end
    chk("hold tipY", 32'(tipY0), 32'd360);
    check_pixel(215, 385, "hold");

    // Release: one step down every second frame, rest after 14 more frames.
    for (int k = 1; k <= 17; k++) begin
      do_frame(1'b0);
      chk($sformatf("fall f%0d step", k), 32'(ang0),
          32'((7 - (k - 1) / 2 < 0) ? 0 : 7 - (k - 1) / 2));
      chk($sformatf("fall f%0d state", k), 32'(st0), (k < 15) ? 32'd3 : 32'd0);
      check_fsm($sformatf("fall f%0d", k));
    end

    // Release at step 3, re-press at step 2.
    for (int k = 1; k <= 4; k++) do_frame(1'b1);
    chk("retrig up3", 32'(ang0), 32'd3);
    do_frame(1'b0);
    chk("retrig rel state", 32'(st0), 32'd3);
    chk("retrig rel step", 32'(ang0), 32'd3);
    do_frame(1'b0);
    do_frame(1'b0);
    chk("retrig down2", 32'(ang0), 32'd2);
    do_frame(1'b1);
    chk("retrig press state", 32'(st0), 32'd1);
    chk("retrig press step", 32'(ang0), 32'd2);
    chk("retrig press kick", 32'(kick0), 32'd1);
    do_frame(1'b1);
    chk("retrig climb3", 32'(ang0), 32'd3);
    do_frame(1'b1);
    chk("retrig climb4", 32'(ang0), 32'd4);
    check_fsm("retrig");

    // Reset in the middle of RISING, with the right flipper drawing.
    check_pixel(155, 395, "pre-reset");
    chk("pre-reset dr1 on", 32'(dr1), 32'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_values("async reset");
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    do_frame(1'b0);
    chk("post-reset stays rest", 32'(st0), 32'd0);
    chk("post-reset step", 32'(ang0), 32'd0);
    do_frame(1'b1);
    chk("post-reset press", 32'(st0), 32'd1);
    check_fsm("post-reset");

    // Randomized frames and pixels against the model.
    btn = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 4) == 0) btn = ~btn;
      do_frame(btn);
      check_fsm($sformatf("rand f%0d", k));
      ul = $urandom_range(0, 78) - 8;
      vl = ((30 - 10 * m_step) * ul) / 60 + $urandom_range(0, 16) - 8;
      px = ($urandom_range(0, 1) == 0) ? 185 + ul : 185 - ul;
      py = 400 + vl;
      check_pixel(px, py, $sformatf("rand f%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/flipper_unit.md
FLIPPER_UNIT -- requirements
Module: flipper_unit

Interface
REQ-001 Parameters SHALL be as follows (name, default, meaning):
- MIRROR, 0: 0 = left flipper, tip to the right of the pivot; 1 = right flipper, tip to the left.
- PIVOT_X, 185: fixed pivot X, in pixels.
- PIVOT_Y, 400: fixed pivot Y, in pixels.
- LENGTH, 60: horizontal pivot-to-tip distance (1..255).
- THICKNESS, 5: half-thickness of the drawn bar (1..15).
- N_STEPS, 8: number of angle positions (2..16).
- DROP, 30: tip Y offset at rest; positive means below the pivot.
- STEP_DY, 10: tip Y change per angle step.
- UP_FRAMES, 1: frames per step while rising (1..15).
- DOWN_FRAMES, 2: frames per step while falling (1..15).
- OBJECT_COLOR, 8'h5B: draw colour.

REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1: sole clock.
- reset, in, 1: asynchronous, active-high.
- startOfFrame, in, 1: one-cycle pulse per video frame.
- button, in, 1: level; 1 = flipper commanded up.
- pixelX, in, 11 signed: current VGA pixel X.
- pixelY, in, 11 signed: current VGA pixel Y.
- drawingRequest, out, 1: pixel lies on the flipper.
- RGBout, out, 8: pixel colour.
- offsetX, out, 11: pixel offset from the pivot.
- offsetY, out, 11: pixel offset from the pivot.
- tipX, out, 11 signed: current tip X.
- tipY, out, 11 signed: current tip Y.
- angleStep, out, 4: current angle index.
- kick, out, 1: flipper is moving up.
- state, out, 2: FSM state.

Function
REQ-003 The FSM SHALL have the states REST=0, RISING=1, HOLD=2, FALLING=3; the state output SHALL equal the current encoding.
REQ-004 angleStep, state and the frame counter SHALL update only in cycles where startOfFrame=1; in every other cycle they SHALL hold.
REQ-005 On a startOfFrame cycle, the frame counter SHALL increment; a "step tick" SHALL occur when the counter reaches UP_FRAMES-1 (RISING) or DOWN_FRAMES-1 (FALLING), and the counter SHALL then clear.
REQ-006 REST: if button=1 at the frame pulse, go to RISING and clear the counter; angleStep SHALL be 0.
REQ-007 RISING: on a step tick, angleStep+1; when angleStep would reach N_STEPS-1, load N_STEPS-1 and go to HOLD; if button=0 at the frame pulse, go to FALLING with counter cleared and no step change.
REQ-008 HOLD: angleStep SHALL stay at N_STEPS-1; if button=0 at the frame pulse, go to FALLING.
REQ-009 FALLING: on a step tick, angleStep-1; reaching 0 goes to REST; if button=1 at the frame pulse, go to RISING with counter cleared (re-trigger mid-fall).
REQ-010 angleStep SHALL never wrap: it is saturated to 0..N_STEPS-1 in all states.
REQ-011 kick SHALL be 1 if and only if state=RISING.
REQ-012 dy SHALL be defined as DROP - angleStep*STEP_DY (signed); tipY SHALL be PIVOT_Y+dy; tipX SHALL be PIVOT_X+LENGTH when MIRROR=0 and PIVOT_X-LENGTH when MIRROR=1; tipX/tipY SHALL be registered with angleStep.
REQ-013 Pixel-relative coordinates SHALL be defined as:
- u = pixelX-PIVOT_X when MIRROR=0, and PIVOT_X-pixelX when MIRROR=1;
- v = pixelY-PIVOT_Y.
REQ-014 inside SHALL be true when all of the following hold:
- |v*LENGTH - dy*u| <= LENGTH*THICKNESS;
- -THICKNESS <= u <= LENGTH+THICKNESS;
- min(0,dy)-THICKNESS <= v <= max(0,dy)+THICKNESS.
REQ-015 All products in REQ-014 SHALL be computed signed in at least 24 bits, with no truncation before the compare.
REQ-016 Drawing outputs SHALL be registered, with 1-cycle latency from pixelX/pixelY:
- inside: drawingRequest=1, RGBout=OBJECT_COLOR, offsetX=u, offsetY=v;
- otherwise: drawingRequest=0, RGBout=8'hFF (transparent), offsetX=0, offsetY=0.
REQ-017 If startOfFrame and a button change occur in the same cycle, the button value sampled in that cycle SHALL govern the transition.

Reset
REQ-018 While reset=1, the block SHALL hold, asynchronously:
- state=REST, angleStep=0, frame counter=0, kick=0;
- tipX/tipY at their rest values (245/430 with defaults);
- drawingRequest=0, RGBout=8'hFF, offsetX=0, offsetY=0.
REQ-019 Reset asserted mid-RISING or mid-FALLING SHALL abort the motion; after release the block SHALL restart from REST and need a new button=1 frame to move.

Verification
REQ-020 The bench SHALL cover these scenarios (defaults unless stated):
- Reset, button=0, 10 frames -> state=REST, angleStep=0, tipY=430, kick=0 throughout.
- button=1 held, UP_FRAMES=1 -> state goes to RISING at frame 1; angleStep 1..7 over frames 2..8; HOLD at step 7; tipY=360; kick=1 only while RISING.
- From HOLD, button=0 -> FALLING; angleStep decrements every 2nd frame; REST after 14 frames; never below 0.
- Button released at angleStep=3 while rising -> FALLING; button re-pressed at step 2 -> RISING, climbing again from 2.
- At REST, pixel (215,415) -> drawingRequest=1, RGBout=8'h5B, offsetX=30, offsetY=15 one cycle later; pixel (215,440) -> drawingRequest=0, RGBout=8'hFF.
- MIRROR=1 at REST: tipX=125; pixel (155,415) -> drawingRequest=1; reset pulse during RISING -> all outputs at reset values within the same cycle.
